// File: rtl/recip_nr_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : recip_nr_unit_if
//  Brief    : Divisor-in / reciprocal-out valid-ready bundle for recip_nr_unit.
//  Revision : 1.0  initial release
// ============================================================================
interface recip_nr_unit_if #(
    parameter int DATA_W  = 16,
    parameter int SHIFT_W = $clog2(DATA_W)
);
    logic               i_valid;
    logic               o_ready;
    logic [DATA_W-1:0]  i_divisor;
    logic               o_valid;
    logic               i_ready;
    logic [DATA_W-1:0]  o_reciprocal;
    logic [SHIFT_W-1:0] o_shift;
    logic               o_div_zero;

    modport master (
        output i_valid, i_divisor, i_ready,
        input  o_ready, o_valid, o_reciprocal, o_shift, o_div_zero
    );

    modport slave (
        input  i_valid, i_divisor, i_ready,
        output o_ready, o_valid, o_reciprocal, o_shift, o_div_zero
    );
endinterface

`default_nettype wire

// File: rtl/recip_nr_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : recip_nr_unit
//  Brief    : LUT-seeded Newton-Raphson reciprocal on one shared multiplier.
//             Define RECIP_ROUND_EN to round (instead of truncate) the final y.
//  Revision : 1.0  initial release
// ============================================================================
module recip_nr_unit #(
    parameter int DATA_W   = 16,
    parameter int LUT_BITS = 5,
    parameter int ITER     = 1,
    parameter int GUARD    = 2,
    parameter int SHIFT_W  = $clog2(DATA_W)
) (
    input  wire            i_clk,
    input  wire            i_rst_n,
    recip_nr_unit_if.slave bus
);

    localparam int c_MAG_W = DATA_W - 1;
    localparam int c_W     = DATA_W + GUARD;
    localparam int c_EP    = DATA_W - 3;
    localparam int c_LUT_N = 2 ** LUT_BITS;
    localparam logic [DATA_W-1:0] c_SAT = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NORM  = 3'd1,
        S_MUL_E = 3'd2,
        S_MUL_Y = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // round(2^(DATA_W-1) / (1 + (k+0.5)/2^LUT_BITS)) in integer form
    function automatic logic [DATA_W-1:0] seed_calc(input int k);
        longint num;
        longint den;
        num = longint'(1) << (DATA_W - 1 + LUT_BITS + 1);
        den = (longint'(1) << (LUT_BITS + 1)) + 2 * longint'(k) + 1;
        return DATA_W'((2 * num + den) / (2 * den));
    endfunction

    // y carries DATA_W-1+GUARD fraction bits; drop GUARD bits and saturate below 1.0
    function automatic logic [DATA_W-1:0] finalize(input logic [c_W-1:0] y);
        logic [c_W:0]    sum;
        logic [DATA_W:0] q;
`ifdef RECIP_ROUND_EN
        sum = {1'b0, y} + (c_W+1)'(2 ** (GUARD - 1));
`else
        sum = {1'b0, y};
`endif
        q = sum[c_W:GUARD];
        if (|q[DATA_W:DATA_W-1]) return c_SAT;
        return q[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] w_seed_tab [c_LUT_N];

    for (genvar k = 0; k < c_LUT_N; k++) begin : g_seed
        localparam logic [DATA_W-1:0] c_SEED = seed_calc(k);
        assign w_seed_tab[k] = c_SEED;
    end

    state_t               r_state;
    logic [c_MAG_W-1:0]   r_mag;
    logic [c_MAG_W-1:0]   r_m;
    logic [SHIFT_W-1:0]   r_nshift;
    logic                 r_zero;
    logic [c_W-1:0]       r_y;
    logic [c_W+1:0]       r_e;
    logic [1:0]           r_iter;
    logic                 r_ready;
    logic                 r_valid;
    logic [DATA_W-1:0]    r_recip;
    logic [SHIFT_W-1:0]   r_shift;
    logic                 r_dz;

    logic [SHIFT_W-1:0]   w_lead;
    logic [SHIFT_W-1:0]   w_shift;
    logic [c_MAG_W-1:0]   w_m;
    logic [LUT_BITS-1:0]  w_idx;
    logic [DATA_W-1:0]    w_seed;
    logic [c_W+1:0]       w_t;
    logic [c_W+1:0]       w_mul_b;
    logic [2*c_W+1:0]     w_prod;
    logic                 w_unused_msb;
    logic [c_EP+1:0]      w_unused_prod;

    // Leading-one detect; an all-zero magnitude yields the maximum shift
    always_comb begin
        w_lead = '0;
        for (int i = 0; i < c_MAG_W; i++) begin
            if (r_mag[i]) w_lead = SHIFT_W'(i);
        end
    end

    assign w_shift = SHIFT_W'(c_MAG_W - 1) - w_lead;
    assign w_m     = r_mag << w_shift;
    assign w_idx   = w_m[c_MAG_W-2 -: LUT_BITS];
    assign w_seed  = w_seed_tab[w_idx];

    // Shared multiplier: y*m in MUL_E, y*(2-e) in MUL_Y
    assign w_t     = {2'b10, {c_W{1'b0}}} - r_e;
    assign w_mul_b = (r_state == S_MUL_E) ? {{(c_W+2-c_MAG_W){1'b0}}, r_m} : w_t;
    assign w_prod  = {{(c_W+2){1'b0}}, r_y} * {{c_W{1'b0}}, w_mul_b};

    assign w_unused_msb  = bus.i_divisor[DATA_W-1];
    assign w_unused_prod = {w_prod[2*c_W+1:2*c_W], w_prod[c_EP-1:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_mag    <= '0;
            r_m      <= '0;
            r_nshift <= '0;
            r_zero   <= 1'b0;
            r_y      <= '0;
            r_e      <= '0;
            r_iter   <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_recip  <= '0;
            r_shift  <= '0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        r_mag   <= bus.i_divisor[c_MAG_W-1:0];
                        r_ready <= 1'b0;
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_m      <= w_m;
                    r_nshift <= w_shift;
                    r_zero   <= (r_mag == '0);
                    r_y      <= {w_seed, {GUARD{1'b0}}};
                    r_iter   <= 2'(ITER);
                    r_state  <= (ITER > 0) ? S_MUL_E : S_DONE;
                end
                S_MUL_E: begin
                    r_e     <= w_prod[c_EP +: c_W+2];
                    r_state <= S_MUL_Y;
                end
                S_MUL_Y: begin
                    r_y     <= w_prod[c_W +: c_W];
                    r_iter  <= r_iter - 2'd1;
                    r_state <= (r_iter == 2'd1) ? S_DONE : S_MUL_E;
                end
                S_DONE: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_recip <= r_zero ? c_SAT : finalize(r_y);
                        r_shift <= r_nshift;
                        r_dz    <= r_zero;
                    end else if (bus.i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ready      = r_ready;
    assign bus.o_valid      = r_valid;
    assign bus.o_reciprocal = r_recip;
    assign bus.o_shift      = r_shift;
    assign bus.o_div_zero   = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_recip_nr_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_recip_nr_unit
//  Brief    : Vector table, random traffic vs real-valued model, handshake/reset
//             corner sequences for an ITER=1 and an ITER=0 instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_recip_nr_unit;

    logic i_clk = 1'b0;
    logic i_rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 i_clk = ~i_clk;

    recip_nr_unit_if #(.DATA_W(16), .SHIFT_W(4)) bus1 ();
    recip_nr_unit_if #(.DATA_W(16), .SHIFT_W(4)) bus0 ();

    recip_nr_unit #(.DATA_W(16), .LUT_BITS(5), .ITER(1), .GUARD(2), .SHIFT_W(4)) u_dut1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus1)
    );

    recip_nr_unit #(.DATA_W(16), .LUT_BITS(5), .ITER(0), .GUARD(2), .SHIFT_W(4)) u_dut0 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus0)
    );

    typedef struct {
        logic [15:0] div;
        bit          it1;
        int          recip;
        int          shift;
        bit          dz;
        int          lat;
    } vec_t;

    vec_t tbl [12];

    function automatic int seed_of(input int idx);
        return $rtoi(32768.0 / (1.0 + (idx + 0.5) / 32.0) + 0.5);
    endfunction

    function automatic int shift_of(input int mag);
        int s;
        if (mag == 0) return 14;
        s = 0;
        while ((mag << s) < 16384) s++;
        return s;
    endfunction

    function automatic real mant_of(input int mag);
        return $itor(mag << shift_of(mag)) / 16384.0;
    endfunction

    function automatic int seed_model(input int mag);
        return seed_of($rtoi((mant_of(mag) - 1.0) * 32.0));
    endfunction

    // One exact Newton step from the seed, in LSBs of 2^-15, capped below 1.0
    function automatic real nr1_model(input int mag);
        real m, y0, y1;
        m  = mant_of(mag);
        y0 = seed_model(mag) / 32768.0;
        y1 = y0 * (2.0 - m * y0) * 32768.0;
        return (y1 > 32767.0) ? 32767.0 : y1;
    endfunction

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic run(input bit u, input logic [15:0] d, output logic [15:0] r,
                       output logic [3:0] s, output logic z, output int lat);
        int n;
        n = 0;
        @(negedge i_clk);
        while (!(u ? bus1.o_ready : bus0.o_ready) && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (u) begin bus1.i_divisor = d; bus1.i_valid = 1'b1; bus1.i_ready = 1'b1; end
        else   begin bus0.i_divisor = d; bus0.i_valid = 1'b1; bus0.i_ready = 1'b1; end
        @(posedge i_clk); #1;
        if (u) bus1.i_valid = 1'b0; else bus0.i_valid = 1'b0;
        lat = 0;
        while (!(u ? bus1.o_valid : bus0.o_valid) && lat < 20) begin
            @(posedge i_clk); #1;
            lat++;
        end
        r = u ? bus1.o_reciprocal : bus0.o_reciprocal;
        s = u ? bus1.o_shift      : bus0.o_shift;
        z = u ? bus1.o_div_zero   : bus0.o_div_zero;
        @(posedge i_clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] r, r0, d;
        logic [3:0]  s;
        logic        z;
        int          lat, mag, tol, seen, n;
        real         er;

        tbl[0]  = '{16'h4000, 1'b1, 32760,  0, 1'b0, 4};
        tbl[1]  = '{16'h0001, 1'b1, 32760, 14, 1'b0, 4};
        tbl[2]  = '{16'h6000, 1'b1, 21843,  0, 1'b0, 4};
        tbl[3]  = '{16'h0003, 1'b1, 21843, 13, 1'b0, 4};
        tbl[4]  = '{16'h0000, 1'b1, 32767, 14, 1'b1, 4};
        tbl[5]  = '{16'h2000, 1'b1, 32760,  1, 1'b0, 4};
        tbl[6]  = '{16'h8000, 1'b1, 32767, 14, 1'b1, 4};
        tbl[7]  = '{16'hC000, 1'b1, 32760,  0, 1'b0, 4};
        tbl[8]  = '{16'h4000, 1'b0, 32264,  0, 1'b0, 2};
        tbl[9]  = '{16'h6000, 1'b0, 21620,  0, 1'b0, 2};
        tbl[10] = '{16'h0000, 1'b0, 32767, 14, 1'b1, 2};
        tbl[11] = '{16'h0010, 1'b0, 32264, 10, 1'b0, 2};

        bus1.i_valid = 1'b0; bus1.i_ready = 1'b1; bus1.i_divisor = '0;
        bus0.i_valid = 1'b0; bus0.i_ready = 1'b1; bus0.i_divisor = '0;
        i_rst_n = 1'b1;
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_ready1", bus1.o_ready == 1'b1, bus1.o_ready, 1);
        chk("rst_valid1", bus1.o_valid == 1'b0, bus1.o_valid, 0);
        chk("rst_recip1", bus1.o_reciprocal == 16'h0, bus1.o_reciprocal, 0);
        chk("rst_shift1", bus1.o_shift == 4'h0, bus1.o_shift, 0);
        chk("rst_dz1",    bus1.o_div_zero == 1'b0, bus1.o_div_zero, 0);
        chk("rst_ready0", bus0.o_ready == 1'b1, bus0.o_ready, 1);
        chk("rst_valid0", bus0.o_valid == 1'b0, bus0.o_valid, 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run(tbl[i].it1, tbl[i].div, r, s, z, lat);
            tol = tbl[i].it1 ? 1 : 0;
            chk($sformatf("vec%0d_recip", i),
                (int'(r) >= tbl[i].recip - tol) && (int'(r) <= tbl[i].recip + tol), r, tbl[i].recip);
            chk($sformatf("vec%0d_shift", i), int'(s) == tbl[i].shift, s, tbl[i].shift);
            chk($sformatf("vec%0d_dz", i), z == tbl[i].dz, z, tbl[i].dz);
            chk($sformatf("vec%0d_lat", i), lat == tbl[i].lat, lat, tbl[i].lat);
        end

        // Truncation through the guard bits stays within about 1.25 LSB of the exact step
        for (int k = 0; k < 1500; k++) begin
            d   = 16'($urandom) >> $urandom_range(0, 15);
            mag = int'(d[14:0]);
            run(1'b1, d, r, s, z, lat);
            er  = (mag == 0) ? 32767.0 : nr1_model(mag);
            chk($sformatf("rand1_recip d=%h", d),
                ($itor(r) - er <= 1.5) && ($itor(r) - er >= -1.5), r, $rtoi(er));
            chk($sformatf("rand1_shift d=%h", d), int'(s) == shift_of(mag), s, shift_of(mag));
            chk($sformatf("rand1_dz_lat d=%h", d), (z == (mag == 0)) && lat == 4, lat, 4);
        end

        for (int k = 0; k < 800; k++) begin
            d   = 16'($urandom) >> $urandom_range(0, 15);
            mag = int'(d[14:0]);
            run(1'b0, d, r, s, z, lat);
            n   = (mag == 0) ? 32767 : seed_model(mag);
            chk($sformatf("rand0_recip d=%h", d), int'(r) == n, r, n);
            chk($sformatf("rand0_shift d=%h", d), int'(s) == shift_of(mag), s, shift_of(mag));
        end

        // Backpressure: result held, new divisor ignored while stalled
        n = 0;
        @(negedge i_clk);
        while (!bus1.o_ready && n < 20) begin @(negedge i_clk); n++; end
        bus1.i_ready = 1'b0; bus1.i_divisor = 16'h6000; bus1.i_valid = 1'b1;
        @(posedge i_clk); #1;
        bus1.i_divisor = 16'h4000;
        lat = 0;
        while (!bus1.o_valid && lat < 20) begin @(posedge i_clk); #1; lat++; end
        chk("bp_lat", lat == 4, lat, 4);
        r0 = bus1.o_reciprocal;
        chk("bp_recip", int'(r0) >= 21842 && int'(r0) <= 21844, r0, 21843);
        for (int c = 0; c < 6; c++) begin
            @(posedge i_clk); #1;
            chk("bp_hold_valid", bus1.o_valid == 1'b1, bus1.o_valid, 1);
            chk("bp_hold_recip", bus1.o_reciprocal == r0, bus1.o_reciprocal, r0);
            chk("bp_hold_shift", bus1.o_shift == 4'd0, bus1.o_shift, 0);
            chk("bp_ready_low", bus1.o_ready == 1'b0, bus1.o_ready, 0);
        end
        @(negedge i_clk);
        bus1.i_valid = 1'b0; bus1.i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("bp_xfer_valid", bus1.o_valid == 1'b0, bus1.o_valid, 0);
        chk("bp_xfer_ready", bus1.o_ready == 1'b1, bus1.o_ready, 1);
        seen = 0;
        repeat (8) begin @(posedge i_clk); #1; if (bus1.o_valid) seen++; end
        chk("bp_no_extra", seen == 0, seen, 0);

        // Reset while the multiplier is busy
        @(negedge i_clk);
        bus1.i_divisor = 16'h4000; bus1.i_valid = 1'b1;
        @(posedge i_clk); #1;
        bus1.i_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", bus1.o_valid == 1'b0, bus1.o_valid, 0);
        chk("rst_mid_ready", bus1.o_ready == 1'b1, bus1.o_ready, 1);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        seen = 0;
        repeat (10) begin @(posedge i_clk); #1; if (bus1.o_valid) seen++; end
        chk("rst_no_stale", seen == 0, seen, 0);
        run(1'b1, 16'h6000, r, s, z, lat);
        chk("rst_after_recip", int'(r) >= 21842 && int'(r) <= 21844, r, 21843);
        chk("rst_after_lat", lat == 4, lat, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
